alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 57 +++++
 rtl/alu_iter.sv | 157 +++++++++++++++
 tb/tb_alu_iter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the iterative ALU: opcode encoding, FSM
//               state encoding and a small opcode classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encoding; the numeric values are part of the interface.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_ROR  = 3'b001,
        ALU_NAND = 3'b010,
        ALU_PASS = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_ROL  = 3'b111
    } alu_op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } alu_state_t;

    // Only the multiply needs the RUN state; everything else completes
    // through the single-cycle path.
    function automatic logic op_is_multicycle(input alu_op_t op);
        return op == ALU_MUL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Shift-add multiplier, one multiplier bit per cycle. The load
//               edge already folds in bit 0, so after W-1 further cycles the
//               low W bits of a*b sit on product and last is high.
// Ports       : clk, reset  - clock / synchronous active-high reset
//               load        - capture a, b and start a new product
//               a, b        - multiplicand / multiplier
//               product     - low W bits of a*b (valid while last is high)
//               last        - final partial product has been accumulated
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product,
    output logic         last
);

    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(W);

    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_mcand;
    logic [W-1:0]     r_mplier;
    logic [CNT_W-1:0] r_cnt;   // number of multiplier bits consumed

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_acc    <= b[0] ? a : '0;
            r_mcand  <= a << 1;
            r_mplier <= b >> 1;
            r_cnt    <= CNT_W'(1);
        end else if (r_cnt != '0 && r_cnt != c_cnt_last) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign product = r_acc;
    assign last    = (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter
// Description : Small ALU with one iterative (multi-cycle) multiply. Single
//               cycle ops are captured on the start edge and retired on the
//               following edge; MUL runs W cycles in the RUN state.
// Ports       : clk, reset        - clock / synchronous active-high reset
//               start, alu_cmd    - request and opcode (sampled in IDLE)
//               inA, inB          - operands, captured with start
//               busy              - multi-cycle op in flight
//               done              - one-cycle pulse when rslt/flags update
//               rslt, pari, eq,
//               zero, carry       - registered result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter
    import alu_pkg::*;
#(
    parameter int W    = 8,
    parameter int SH_W = $clog2(W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  alu_op_t      alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rslt,
    output logic         pari,
    output logic         eq,
    output logic         zero,
    output logic         carry
);

    alu_state_t   r_state;
    logic         r_pend;   // a single-cycle op was captured last edge
    alu_op_t      r_cmd;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;

    logic [W-1:0] w_res;
    logic         w_carry;
    logic [W:0]   w_sum;
    logic [SH_W-1:0] w_sh;
    logic [SH_W:0]   w_inv_sh;
    logic [W-1:0] w_ror;
    logic [W-1:0] w_rol;
    logic         w_mul_load;
    logic [W-1:0] w_mul_product;
    logic         w_mul_last;

    // Rotates: the complementary shift equals W when the amount is 0, which
    // shifts everything out and leaves the identity.
    assign w_sh     = r_a[SH_W-1:0];
    assign w_inv_sh = (SH_W+1)'(W) - {1'b0, w_sh};
    assign w_ror    = (r_b >> w_sh) | (r_b << w_inv_sh);
    assign w_rol    = (r_b << w_sh) | (r_b >> w_inv_sh);
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (r_cmd)
            ALU_ADD: begin
                w_res   = w_sum[W-1:0];
                w_carry = w_sum[W];
            end
            ALU_ROR:  w_res = w_ror;
            ALU_NAND: w_res = ~(r_a & r_b);
            ALU_PASS: w_res = r_b;
            ALU_SUB: begin
                w_res   = r_a - r_b;
                w_carry = (r_a >= r_b);
            end
            ALU_XOR:  w_res = r_a ^ r_b;
            ALU_ROL:  w_res = w_rol;
            default:  w_res = '0;   // MUL result comes from the multiplier
        endcase
    end

    assign w_mul_load = (r_state == IDLE) && start && op_is_multicycle(alu_cmd);

    alu_mul_iter #(
        .W (W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (w_mul_load),
        .a       (inA),
        .b       (inB),
        .product (w_mul_product),
        .last    (w_mul_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_cmd   <= ALU_ADD;
            r_a     <= '0;
            r_b     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rslt    <= '0;
            pari    <= 1'b0;
            eq      <= 1'b0;
            zero    <= 1'b0;
            carry   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Retire the op captured last edge while possibly
                    // capturing the next one: one single-cycle op per cycle.
                    if (r_pend) begin
                        rslt  <= w_res;
                        pari  <= ^w_res;
                        zero  <= (w_res == '0);
                        eq    <= (r_a == r_b);
                        carry <= w_carry;
                        done  <= 1'b1;
                    end
                    r_pend <= 1'b0;
                    if (start) begin
                        r_cmd <= alu_cmd;
                        r_a   <= inA;
                        r_b   <= inB;
                        if (op_is_multicycle(alu_cmd)) begin
                            r_state <= RUN;
                            busy    <= 1'b1;
                        end else begin
                            r_pend <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    if (w_mul_last) begin
                        rslt    <= w_mul_product;
                        pari    <= ^w_mul_product;
                        zero    <= (w_mul_product == '0);
                        eq      <= (r_a == r_b);
                        carry   <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_iter
// Description : Self-checking bench for alu_iter (W=8): directed vectors,
//               back-to-back ops, MUL interference and reset abort cases,
//               then randomized ops against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iter;
    import alu_pkg::*;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         reset;
    logic         start;
    alu_op_t      alu_cmd;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         busy;
    logic         done;
    logic [W-1:0] rslt;
    logic         pari;
    logic         eq;
    logic         zero;
    logic         carry;

    int n_checks;
    int n_fail;

    alu_iter #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .alu_cmd (alu_cmd),
        .inA     (inA),
        .inB     (inB),
        .busy    (busy),
        .done    (done),
        .rslt    (rslt),
        .pari    (pari),
        .eq      (eq),
        .zero    (zero),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model straight from the opcode definitions.
    task automatic model(input int cmd, input int a, input int b,
                         output int r, output int c, output int p,
                         output int z, output int e);
        int amt;
        amt = a % W;
        c = 0;
        case (cmd)
            0: begin r = (a + b) & MASK; c = ((a + b) > MASK) ? 1 : 0; end
            1: r = ((b >> amt) | (b << (W - amt))) & MASK;
            2: r = ~(a & b) & MASK;
            3: r = b;
            4: begin r = (a - b) & MASK; c = (a >= b) ? 1 : 0; end
            5: r = (a * b) & MASK;
            6: r = (a ^ b) & MASK;
            default: r = ((b << amt) | (b >> (W - amt))) & MASK;
        endcase
        p = $countones(r) % 2;
        z = (r == 0) ? 1 : 0;
        e = (a == b) ? 1 : 0;
    endtask

    task automatic check_outputs(input string tag, input int r, input int c,
                                 input int p, input int z, input int e);
        chk({tag, "_rslt"},  int'(rslt),  r);
        chk({tag, "_carry"}, int'(carry), c);
        chk({tag, "_pari"},  int'(pari),  p);
        chk({tag, "_zero"},  int'(zero),  z);
        chk({tag, "_eq"},    int'(eq),    e);
    endtask

    // Issue one op, scramble the inputs after the start edge, measure the
    // latency, check busy each cycle, results, and the one-cycle done pulse.
    task automatic run_op(input string tag, input int cmd, input int a, input int b);
        int r, c, p, z, e, lat, exp_lat;
        model(cmd, a, b, r, c, p, z, e);
        exp_lat = (cmd == 5) ? W : 1;
        start   = 1'b1;
        alu_cmd = alu_op_t'(cmd[2:0]);
        inA     = a[W-1:0];
        inB     = b[W-1:0];
        tick();
        start   = 1'b0;
        inA     = W'($urandom);
        inB     = W'($urandom);
        alu_cmd = alu_op_t'($urandom_range(0, 7));
        lat = 0;
        while (!done && lat < 3 * W) begin
            chk({tag, "_busy"}, int'(busy), (cmd == 5) ? 1 : 0);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        check_outputs(tag, r, c, p, z, e);
        tick();
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_hold"}, int'(rslt), r);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  int'(busy),  0);
        chk({tag, "_done"},  int'(done),  0);
        check_outputs(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int r, c, p, z, e, n_done;
        int exp_q[$];
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b1;
        alu_cmd  = ALU_ADD;
        inA      = 8'h01;
        inB      = 8'h01;

        // Reset wins over start.
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_after_reset_done", int'(done), 0);

        // Directed vectors.
        run_op("add_f0_20", 0, 'hF0, 'h20);
        chk("add_f0_20_lit", int'(rslt), 'h10);
        chk("add_f0_20_lit_carry", int'(carry), 1);
        run_op("ror3", 1, 3, 'h81);
        chk("ror3_lit", int'(rslt), 'h30);
        run_op("rol11", 7, 11, 'h81);
        chk("rol11_lit", int'(rslt), 'h0C);
        run_op("ror0", 1, 8, 'h5A);
        chk("ror0_identity", int'(rslt), 'h5A);
        run_op("mul_13_11", 5, 13, 11);
        chk("mul_13_11_lit", int'(rslt), 'h8F);
        chk("mul_13_11_lit_pari", int'(pari), 1);
        run_op("sub_borrow", 4, 3, 9);

        // Start with ADD 1+1 in the middle of a MUL must be ignored.
        start = 1'b1; alu_cmd = ALU_MUL; inA = 8'd7; inB = 8'd9;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            if (i == 3) begin
                start = 1'b1; alu_cmd = ALU_ADD; inA = 8'd1; inB = 8'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                n_done++;
                chk("mid_mul_rslt", int'(rslt), 63);
            end
        end
        chk("mid_mul_done_count", n_done, 1);
        chk("mid_mul_final_rslt", int'(rslt), 63);

        // New start accepted in the cycle where MUL done is high.
        start = 1'b1; alu_cmd = ALU_MUL; inA = 8'd20; inB = 8'd30;
        tick();
        start = 1'b0;
        n_done = 0;
        while (!done && n_done < 3 * W) begin
            tick();
            n_done++;
        end
        chk("mul_then_add_mul_rslt", int'(rslt), (20 * 30) & MASK);
        start = 1'b1; alu_cmd = ALU_ADD; inA = 8'd40; inB = 8'd2;
        tick();
        start = 1'b0;
        chk("mul_then_add_capture_done", int'(done), 0);
        chk("mul_then_add_capture_busy", int'(busy), 0);
        tick();
        chk("mul_then_add_done", int'(done), 1);
        chk("mul_then_add_rslt", int'(rslt), 42);
        tick();

        // Back-to-back single-cycle ops, one per cycle.
        for (int i = 0; i < 6; i++) begin
            int cmd, a, b;
            cmd = $urandom_range(0, 7);
            if (cmd == 5) cmd = 6;
            a = $urandom_range(0, MASK);
            b = $urandom_range(0, MASK);
            model(cmd, a, b, r, c, p, z, e);
            exp_q.push_back(r);
            start = 1'b1; alu_cmd = alu_op_t'(cmd[2:0]); inA = a[W-1:0]; inB = b[W-1:0];
            tick();
            if (i > 0) begin
                chk("b2b_done", int'(done), 1);
                chk("b2b_rslt", int'(rslt), exp_q.pop_front());
            end
        end
        start = 1'b0;
        tick();
        chk("b2b_last_done", int'(done), 1);
        chk("b2b_last_rslt", int'(rslt), exp_q.pop_front());
        tick();
        chk("b2b_idle_done", int'(done), 0);

        // Reset at edge k+4 of a MUL aborts it without a done pulse.
        start = 1'b1; alu_cmd = ALU_MUL; inA = 8'd13; inB = 8'd11;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mul_abort");
        n_done = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("mul_abort_no_done", n_done, 0);
        chk("mul_abort_rslt", int'(rslt), 0);
        run_op("sub_5_5", 4, 5, 5);
        chk("sub_5_5_lit_zero", int'(zero), 1);
        chk("sub_5_5_lit_eq", int'(eq), 1);
        chk("sub_5_5_lit_carry", int'(carry), 1);

        // Randomized ops.
        for (int i = 0; i < 150; i++) begin
            int cmd, a, b;
            cmd = $urandom_range(0, 7);
            a   = $urandom_range(0, MASK);
            b   = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, MASK);
            run_op("rand", cmd, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
